// File: rtl/bcd_updown_cnt_pkg.sv
// bcd_updown_cnt_pkg: shared BCD digit constants, direction encodings and clamp helper
package bcd_updown_cnt_pkg;

   localparam int DIGIT_W = 4;
   localparam logic [DIGIT_W-1:0] MAX_DIGIT = 4'd9;
   localparam logic UP = 1'b1;
   localparam logic DN = 1'b0;

   // Any out-of-range nibble saturates to 9 so the counter never holds invalid BCD
   function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] d);
      return (d > MAX_DIGIT) ? MAX_DIGIT : d;
   endfunction

endpackage

// File: rtl/bcd_updown_cnt_digit.sv
// bcd_digit: one combinational BCD digit stage with ripple carry/borrow
module bcd_digit
   import bcd_updown_cnt_pkg::*;
(
   input  logic [DIGIT_W-1:0] d,
   input  logic               step_in,
   input  logic               up,
   output logic [DIGIT_W-1:0] nxt,
   output logic               step_out
);

   // A digit wraps 9->0 going up or 0->9 going down and passes the step onward
   always_comb begin
      step_out = step_in && ((up == UP) ? (d == MAX_DIGIT) : (d == '0));
      nxt = !step_in ? d
          : (up == UP) ? ((d == MAX_DIGIT) ? '0 : d + 4'd1)
          : ((d == '0) ? MAX_DIGIT : d - 4'd1);
   end

endmodule

// File: rtl/bcd_updown_cnt.sv
// bcd_updown_cnt: multi-digit BCD up/down counter with load, wrap/hold and done flag
module bcd_updown_cnt
   import bcd_updown_cnt_pkg::*;
#(
   parameter int                    DIGITS   = 2,
   parameter logic [4*DIGITS-1:0]   INIT_VAL = 'h30
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                up,
   input  logic                wrap_en,
   input  logic                load,
   input  logic [4*DIGITS-1:0] load_val,
   output logic [4*DIGITS-1:0] count,
   output logic                tc,
   output logic                done
);

   localparam int W = DIGIT_W * DIGITS;

   logic [W-1:0]    ripple;
   logic [W-1:0]    clamped;
   logic [DIGITS:0] step;
   logic            all_zero;
   logic            all_nines;

   assign step[0] = en;

   genvar i;
   generate
      for (i = 0; i < DIGITS; i++) begin : g_digit
         bcd_digit u_digit (
            .d        (count[DIGIT_W*i +: DIGIT_W]),
            .step_in  (step[i]),
            .up       (up),
            .nxt      (ripple[DIGIT_W*i +: DIGIT_W]),
            .step_out (step[i+1])
         );
         assign clamped[DIGIT_W*i +: DIGIT_W] = clamp_digit(load_val[DIGIT_W*i +: DIGIT_W]);
      end
   endgenerate

   assign all_zero  = (count == '0);
   assign all_nines = (count == {DIGITS{MAX_DIGIT}});
   assign tc        = (up == DN) ? all_zero : all_nines;

   // A carry/borrow out of the top digit means an enabled step at the terminal:
   // the ripple result is already the wrapped value, so hold mode just blocks it
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= INIT_VAL;
         done  <= 1'b0;
      end else if (load) begin
         count <= clamped;
         done  <= 1'b0;
      end else if (en) begin
         if (step[DIGITS] && !wrap_en)
            done <= 1'b1;
         else
            count <= ripple;
      end
   end

endmodule

// File: tb/tb_bcd_updown_cnt.sv
// tb_bcd_updown_cnt: scoreboard bench for 2- and 4-digit BCD up/down counters
module tb_bcd_updown_cnt;

   typedef struct {
      bit          wide;
      logic [15:0] cnt;
      logic        tc;
      logic        done;
      string       name;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, en, up, wrap_en, load;
   logic [7:0]  load_val, count2;
   logic        tc2, done2;
   logic        rst4, en4, up4, wrap4, load4;
   logic [15:0] load_val4, count4;
   logic        tc4, done4;

   int checks = 0;
   int failures = 0;
   exp_t q[$];
   exp_t e;
   logic [15:0] got_cnt;
   logic        got_tc, got_done;

   bcd_updown_cnt #(.DIGITS(2), .INIT_VAL(8'h30)) u_dut2 (
      .clk(clk), .rst(rst), .en(en), .up(up), .wrap_en(wrap_en), .load(load),
      .load_val(load_val), .count(count2), .tc(tc2), .done(done2)
   );

   bcd_updown_cnt #(.DIGITS(4), .INIT_VAL(16'h0030)) u_dut4 (
      .clk(clk), .rst(rst4), .en(en4), .up(up4), .wrap_en(wrap4), .load(load4),
      .load_val(load_val4), .count(count4), .tc(tc4), .done(done4)
   );

   function automatic logic [7:0] to_bcd2(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   // Queue the state expected after the coming edge, then advance one cycle
   task automatic cyc(input bit wide, input logic [15:0] c, input logic t, input logic d, input string nm);
      q.push_back('{wide, c, t, d, nm});
      @(posedge clk);
      @(negedge clk);
   endtask

   // Monitor: after every edge pop one expectation and compare with the DUT it names
   always @(posedge clk) begin
      #1;
      if (q.size() > 0) begin
         e = q.pop_front();
         got_cnt  = e.wide ? count4 : {8'h00, count2};
         got_tc   = e.wide ? tc4 : tc2;
         got_done = e.wide ? done4 : done2;
         checks++;
         if ({got_cnt, got_tc, got_done} !== {e.cnt, e.tc, e.done}) begin
            failures++;
            $display("FAIL %s: got count=%h tc=%b done=%b, expected count=%h tc=%b done=%b",
                     e.name, got_cnt, got_tc, got_done, e.cnt, e.tc, e.done);
         end
      end
   end

   initial begin
      rst = 1; en = 0; up = 0; wrap_en = 0; load = 0; load_val = '0;
      rst4 = 1; en4 = 0; up4 = 0; wrap4 = 0; load4 = 0; load_val4 = '0;
      cyc(0, 16'h30, 0, 0, "reset");
      rst = 0; rst4 = 0;
      // countdown 30 -> 00, then blocked step in hold mode
      en = 1; up = 0; wrap_en = 0;
      for (int i = 1; i <= 30; i++)
         cyc(0, {8'h00, to_bcd2(30 - i)}, (30 - i) == 0, 0, "countdown");
      cyc(0, 16'h00, 1, 1, "hold_zero");
      // load clears done; wrap down and up
      load = 1; load_val = 8'h00; en = 0;
      cyc(0, 16'h00, 1, 0, "load_zero");
      load = 0; en = 1; wrap_en = 1;
      cyc(0, 16'h99, 0, 0, "wrap_down");
      up = 1;
      cyc(0, 16'h00, 0, 0, "wrap_up");
      up = 0; wrap_en = 0;
      cyc(0, 16'h00, 1, 1, "hold_again");
      // load beats enable, clamps low nibble, clears done
      load = 1; load_val = 8'h4A; up = 1;
      cyc(0, 16'h49, 0, 0, "load_clamp");
      load = 0;
      cyc(0, 16'h50, 0, 0, "carry_ripple");
      load = 1; load_val = 8'hFF;
      cyc(0, 16'h99, 1, 0, "load_clamp_both");
      // build count 17 with done=1 retained through wrap steps
      load = 1; load_val = 8'h00; up = 0;
      cyc(0, 16'h00, 1, 0, "load_zero2");
      load = 0;
      cyc(0, 16'h00, 1, 1, "hold_set");
      up = 1; wrap_en = 1;
      for (int i = 1; i <= 17; i++)
         cyc(0, {8'h00, to_bcd2(i)}, 0, 1, "count_up_sticky");
      // reset beats load and enable
      rst = 1; load = 1; load_val = 8'h55;
      cyc(0, 16'h30, 0, 0, "rst_over_load");
      rst = 0; load = 0;
      // enable low: toggling up/wrap_en has no effect on count/done
      en = 0;
      for (int i = 0; i < 5; i++) begin
         up = i[0]; wrap_en = ~i[0];
         cyc(0, 16'h30, 0, 0, "idle_mid");
      end
      load = 1; load_val = 8'h00; en = 1; up = 0; wrap_en = 0;
      cyc(0, 16'h00, 1, 0, "load_zero3");
      load = 0;
      cyc(0, 16'h00, 1, 1, "hold_set2");
      en = 0;
      for (int i = 0; i < 5; i++) begin
         up = i[0]; wrap_en = i[0];
         cyc(0, 16'h00, ~i[0], 1, "idle_terminal");
      end
      // 4-digit: borrow and carry across three digits in one cycle
      load4 = 1; load_val4 = 16'h1000; en4 = 1; up4 = 0;
      cyc(1, 16'h1000, 0, 0, "d4_load");
      load4 = 0;
      cyc(1, 16'h0999, 0, 0, "d4_borrow");
      up4 = 1;
      cyc(1, 16'h1000, 0, 0, "d4_carry");
      load4 = 1; load_val4 = 16'h9999;
      cyc(1, 16'h9999, 1, 0, "d4_load_max");
      load4 = 0; wrap4 = 0;
      cyc(1, 16'h9999, 1, 1, "d4_hold_max");
      wrap4 = 1;
      cyc(1, 16'h0000, 0, 1, "d4_wrap_up");
      repeat (2) @(posedge clk);
      #2;
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bcd_updown_cnt.md
Name: bcd_updown_cnt

Overview:
Parametrised multi-digit BCD counter, the successor to the two-digit countdown timer.
- Counts up or down, selectable per cycle.
- Supports parallel load and either wrap-around or hold-at-terminal mode.
- Provides a terminal-count flag and a sticky done flag.
- Drives seven-segment display paths and lab timers; the digit count sets the display width.

Parameters:
DIGITS, 2, number of BCD digits; count width W = 4*DIGITS.
INIT_VAL, 'h30 (W bits, packed BCD), value loaded on reset; each nibble must be 0..9.

Ports:
clk  input  1  clock; all state changes on rising edge.
rst  input  1  synchronous, active-high reset.
en  input  1  count enable; one step per cycle while high.
up  input  1  direction: 1 = increment, 0 = decrement; sampled each cycle.
wrap_en  input  1  1 = wrap at terminal; 0 = hold at terminal.
load  input  1  parallel load strobe.
load_val  input  W  packed BCD load value; digit 0 in bits [3:0].
count  output  W  packed BCD counter value, registered.
tc  output  1  combinational; high when count equals the terminal for the current `up`.
done  output  1  registered sticky flag; set on a blocked step.

Behaviour:
- Clocking: one clock (clk), synchronous active-high reset (rst). There is no asynchronous path.
- Reset values: count = INIT_VAL; done = 0. tc follows from count.
- Priority on each rising edge: rst > load > en > hold.
- Load:
  - count <= load_val with per-digit clamping: any nibble > 9 becomes 9.
  - done <= 0.
  - Takes effect in one cycle, regardless of en.
- Terminal values: down terminal = all digits 0; up terminal = all digits 9.
- tc is high when up=0 and count is all 0s, or up=1 and count is all 9s.
- Count step (en=1, not at terminal for current direction):
  - Digit 0 changes by ±1.
  - Increment: a digit at 9 becomes 0 and carries to the next digit.
  - Decrement: a digit at 0 becomes 9 and borrows from the next digit.
  - Ripple carry/borrow across all DIGITS within one cycle; the latency is 1 cycle.
- Step at terminal, wrap_en=1:
  - Down: all 0s -> all 9s. Up: all 9s -> all 0s.
  - done is unchanged.
- Step at terminal, wrap_en=0:
  - count holds.
  - done <= 1, and stays 1 until rst or load.
  - This mode reproduces the stop-at-zero timer when up=0.
- en=0: count and done hold. Changes to up or wrap_en have no effect until en=1.
- Direction change mid-count: takes effect on the next enabled edge with no extra latency. An `up` toggle may change tc combinationally while count is steady.
- rst mid-count or mid-load: count returns to INIT_VAL on that edge, and done clears.
- count never holds an invalid BCD nibble. Loaded values are clamped, and the arithmetic is closed over 0..9.
- DIGITS=1 is legal: the terminals are 0 and 9.

Decomposition:
- Shared header of defines:
  - BCD digit width (4).
  - Max digit constant (4'd9).
  - Direction encodings UP=1'b1 and DN=1'b0.
  - The displays also consume this header.
- Sub-module bcd_digit (one per digit, generate loop), combinational:
  - Inputs: digit value, step_in (carry/borrow in), up.
  - Outputs: next digit, step_out.
  - Digit 0's step_in is en.
- Top level contains:
  - The registers.
  - The load clamp.
  - The terminal detect.
  - The wrap/hold mux.
  - The done flag.

Test Plan:
1. DIGITS=2, INIT_VAL='h30; rst=1 one cycle, then en=1, up=0, wrap_en=0 -> count 30,29,...,01,00 over 30 cycles. tc=1 at 00. On the 31st enabled edge count stays 00 and done=1.
2. From count=00, up=0, wrap_en=1, en=1 -> next count=99 with done=0. Then up=1 at 99 -> count=00 on the following edge.
3. load=1, load_val='h4A, en=1 same cycle -> count=49 (load wins, low nibble clamped) and done cleared. Next edge with up=1 -> 50 (carry ripple).
4. DIGITS=4: load 'h1000, up=0, en=1 -> 0999. Then up=1 -> 1000 (borrow/carry through 3 digits in one cycle).
5. Mid-count at 17 with done=1 from a prior hold: assert rst with en=1, load=1 -> count=INIT_VAL and done=0 on that edge; load ignored.
6. en=0 for 5 cycles while toggling up and wrap_en -> count and done unchanged. tc toggles with up only when count is at a terminal.
